// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: rebuilds digit frames from a scanned 7-seg bus; define SEG7_SCAN_ACTIVE_LOW_EN for active-low seg_in/an_in
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    input  logic                    frame_ready,
    output logic                    frame_valid,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    overrun
);
    typedef enum logic {EMPTY, FULL} state_t;
    localparam logic [7:0] SC = 8'(STABLE_CYCLES);
    logic [6:0]              seg_v;
    logic [NUM_DIGITS-1:0]   an_v;
    logic [6:0]              prev_seg_q, prev_seg_d;
    logic [NUM_DIGITS-1:0]   prev_an_q, prev_an_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d, seen_set;
    logic [4*NUM_DIGITS-1:0] shadow_dig_q, shadow_dig_d;
    logic [NUM_DIGITS-1:0]   shadow_err_q, shadow_err_d;
    logic [4*NUM_DIGITS-1:0] dig_q, dig_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    logic                    ovr_q, ovr_d;
    state_t                  state_q, state_d;
    logic [3:0]              dec_val;
    logic                    dec_err;
    logic                    one_hot, same, commit, complete, load;
`ifdef SEG7_SCAN_ACTIVE_LOW_EN
    assign seg_v = ~seg_in;
    assign an_v  = ~an_in;
`else
    assign seg_v = seg_in;
    assign an_v  = an_in;
`endif
    always_comb begin
        dec_err = 1'b0;
        case (seg_v)
            7'b1111110: dec_val = 4'h0;
            7'b0110000: dec_val = 4'h1;
            7'b1101101: dec_val = 4'h2;
            7'b1111001: dec_val = 4'h3;
            7'b0110011: dec_val = 4'h4;
            7'b1011011: dec_val = 4'h5;
            7'b1011111: dec_val = 4'h6;
            7'b1110000: dec_val = 4'h7;
            7'b1111111: dec_val = 4'h8;
            7'b1111011: dec_val = 4'h9;
            7'b0000000: dec_val = 4'hF;
            default: begin
                dec_val = 4'hE;
                dec_err = 1'b1;
            end
        endcase
    end
    // A saturated counter on an unchanged sample is the tail of a dwell that already committed.
    always_comb begin
        one_hot    = $onehot(an_v);
        same       = {seg_v, an_v} == {prev_seg_q, prev_an_q};
        prev_seg_d = seg_v;
        prev_an_d  = an_v;
        cnt_d      = !one_hot ? 8'd0 : !same ? 8'd1 : (cnt_q == SC) ? cnt_q : cnt_q + 8'd1;
        commit     = one_hot && cnt_d == SC && !(same && cnt_q == SC);
        seen_set   = seen_q | (commit ? an_v : '0);
        complete   = commit && &seen_set;
        seen_d     = complete ? '0 : seen_set;
        shadow_dig_d = shadow_dig_q;
        shadow_err_d = shadow_err_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (commit && an_v[k]) begin
                shadow_dig_d[4*k +: 4] = dec_val;
                shadow_err_d[k]        = dec_err;
            end
        end
    end
    always_comb begin
        load    = complete && (state_q == EMPTY || frame_ready);
        dig_d   = load ? shadow_dig_d : dig_q;
        err_d   = load ? shadow_err_d : err_q;
        ovr_d   = ovr_q | (complete && state_q == FULL && !frame_ready);
        state_d = load ? FULL : (state_q == FULL && frame_ready) ? EMPTY : state_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_seg_q   <= '0;
            prev_an_q    <= '0;
            cnt_q        <= '0;
            seen_q       <= '0;
            shadow_dig_q <= '0;
            shadow_err_q <= '0;
            dig_q        <= '0;
            err_q        <= '0;
            ovr_q        <= 1'b0;
            state_q      <= EMPTY;
        end else begin
            prev_seg_q   <= prev_seg_d;
            prev_an_q    <= prev_an_d;
            cnt_q        <= cnt_d;
            seen_q       <= seen_d;
            shadow_dig_q <= shadow_dig_d;
            shadow_err_q <= shadow_err_d;
            dig_q        <= dig_d;
            err_q        <= err_d;
            ovr_q        <= ovr_d;
            state_q      <= state_d;
        end
    end
    assign frame_valid = state_q == FULL;
    assign digits_out  = dig_q;
    assign digit_err   = err_q;
    assign overrun     = ovr_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed plan scenarios plus random scanning against a dwell-length reference model
module tb_seg7_scan_decoder;
    localparam int N = 4;
    localparam int SC = 4;
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [6:0]      seg_in = '0;
    logic [N-1:0]    an_in = '0;
    logic            frame_ready = 1'b0;
    logic            frame_valid;
    logic [4*N-1:0]  digits_out;
    logic [N-1:0]    digit_err;
    logic            overrun;
    int checks = 0;
    int errors = 0;
    logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                             7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    logic [6:0]     m_prev_seg;
    logic [N-1:0]   m_prev_an;
    int             m_run;
    logic [N-1:0]   m_seen;
    logic [3:0]     m_sh [N];
    logic           m_sherr [N];
    logic           m_valid, m_ovr;
    logic [4*N-1:0] m_dig;
    logic [N-1:0]   m_err;

    seg7_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in), .frame_ready(frame_ready),
        .frame_valid(frame_valid), .digits_out(digits_out), .digit_err(digit_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_prev_seg = '0;
        m_prev_an  = '0;
        m_run      = 0;
        m_seen     = '0;
        for (int k = 0; k < N; k++) begin
            m_sh[k]    = '0;
            m_sherr[k] = 1'b0;
        end
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_dig   = '0;
        m_err   = '0;
    endtask

    // A dwell is a run of identical samples; it commits when its length reaches SC exactly.
    task automatic model_step(input logic [6:0] s, input logic [N-1:0] a, input bit rdy);
        bit oh, complete;
        int i, v;
        oh = $countones(a) == 1;
        if (!oh) m_run = 0;
        else if (s == m_prev_seg && a == m_prev_an) m_run++;
        else m_run = 1;
        m_prev_seg = s;
        m_prev_an  = a;
        complete = 0;
        if (oh && m_run == SC) begin
            i = 0;
            for (int k = 0; k < N; k++) if (a[k]) i = k;
            v = -1;
            for (int k = 0; k < 10; k++) if (s == pat[k]) v = k;
            m_sh[i]    = v >= 0 ? 4'(v) : (s == 7'b0) ? 4'hF : 4'hE;
            m_sherr[i] = v < 0 && s != 7'b0;
            m_seen[i]  = 1'b1;
            if (&m_seen) begin
                complete = 1;
                m_seen = '0;
            end
        end
        if (m_valid && rdy) m_valid = 0;
        if (complete) begin
            if (!m_valid) begin
                m_valid = 1;
                for (int k = 0; k < N; k++) begin
                    m_dig[4*k +: 4] = m_sh[k];
                    m_err[k]        = m_sherr[k];
                end
            end else m_ovr = 1;
        end
    endtask

    task automatic tick(input logic [6:0] s, input logic [N-1:0] a, input bit rdy);
`ifdef SEG7_SCAN_ACTIVE_LOW_EN
        seg_in = ~s;
        an_in  = ~a;
`else
        seg_in = s;
        an_in  = a;
`endif
        frame_ready = rdy;
        @(posedge clk);
        model_step(s, a, rdy);
        #1;
        chk("valid", frame_valid, m_valid);
        chk("digits", digits_out, m_dig);
        chk("err", digit_err, m_err);
        chk("overrun", overrun, m_ovr);
    endtask

    task automatic show(input int d, input logic [6:0] s, input int n, input bit rdy);
        for (int t = 0; t < n; t++) tick(s, N'(1 << d), rdy);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        seg_in = '0;
        an_in = '0;
`ifdef SEG7_SCAN_ACTIVE_LOW_EN
        seg_in = '1;
        an_in = '1;
`endif
        frame_ready = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
        chk("rst_valid", frame_valid, 1'b0);
        chk("rst_digits", digits_out, '0);
        chk("rst_err", digit_err, '0);
        chk("rst_overrun", overrun, 1'b0);
    endtask

    initial begin
        model_reset();
        do_reset();
        repeat (20) tick(7'b0, '0, 1'b0);
        chk("idle_valid", frame_valid, 1'b0);

        do_reset();
        show(0, pat[3], 4, 1);
        show(1, pat[4], 4, 1);
        show(2, pat[5], 4, 1);
        show(3, pat[6], 3, 1);
        chk("basic_early", frame_valid, 1'b0);
        show(3, pat[6], 1, 1);
        chk("basic_valid", frame_valid, 1'b1);
        chk("basic_digits", digits_out, 16'h6543);
        chk("basic_err", digit_err, 4'h0);
        tick(7'b0, '0, 1);
        chk("basic_drop", frame_valid, 1'b0);

        do_reset();
        show(0, pat[0], 4, 1);
        show(2, pat[2], 4, 1);
        show(3, pat[3], 4, 1);
        show(1, pat[8], 3, 1);
        show(1, pat[1], 1, 1);
        show(1, pat[8], 3, 1);
        chk("glitch_early", frame_valid, 1'b0);
        show(1, pat[8], 1, 1);
        chk("glitch_valid", frame_valid, 1'b1);
        chk("glitch_digits", digits_out, 16'h3280);

        do_reset();
        show(0, pat[0], 4, 0);
        show(1, pat[1], 4, 0);
        show(2, 7'b1000001, 4, 0);
        show(3, 7'b0000000, 4, 0);
        chk("illegal_digits", digits_out, 16'hFE10);
        chk("illegal_err", digit_err, 4'b0100);

        do_reset();
        for (int d = 0; d < N; d++) show(d, pat[d + 1], 4, 0);
        for (int d = 0; d < N; d++) show(d, pat[d + 5], 4, 0);
        chk("bp_digits", digits_out, 16'h4321);
        chk("bp_overrun", overrun, 1'b1);
        chk("bp_valid", frame_valid, 1'b1);
        tick(7'b0, '0, 1);
        chk("bp_release", frame_valid, 1'b0);

        do_reset();
        for (int d = 0; d < N; d++) show(d, pat[d], 4, 0);
        show(0, pat[9], 2, 0);
        tick(pat[9], 4'b0011, 0);
        show(0, pat[9], 4, 0);
        show(1, pat[8], 4, 0);
        show(2, pat[7], 4, 0);
        show(3, pat[6], 3, 0);
        chk("simul_hold", digits_out, 16'h3210);
        show(3, pat[6], 1, 1);
        chk("simul_valid", frame_valid, 1'b1);
        chk("simul_digits", digits_out, 16'h6789);
        chk("simul_overrun", overrun, 1'b0);

        do_reset();
        for (int r = 0; r < 1200; r++) begin
            logic [6:0] s;
            logic [N-1:0] a;
            int sel, len;
            sel = int'($urandom_range(0, 9));
            s = sel < 8 ? pat[$urandom_range(0, 9)] : sel == 8 ? 7'b0 : 7'($urandom);
            a = $urandom_range(0, 9) == 0 ? N'($urandom) : N'(1 << $urandom_range(0, N - 1));
            len = int'($urandom_range(1, 6));
            for (int t = 0; t < len; t++) tick(s, a, $urandom_range(0, 2) != 0);
            if (r == 600) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
